// File: rtl/uart_pkg.sv
// Shared definitions for the uart_txrx block: FSM state type, default
// line configuration, and the rounded baud divisor helper.
package uart_pkg;

  localparam int DEF_BYTESIZES = 8;
  localparam int DEF_RX_OS     = 16;
  localparam int DEF_TX_OS     = 1;
  localparam int DEF_BAUDRATE  = 115200;
  localparam int DEF_CLOCK_HZ  = 50_000_000;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  // Clocks per tick, rounded to nearest: clk / (baud * os).
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Tick generator: divides the system clock by DIV.
// Ports:
//   clock   - system clock
//   nreset  - synchronous active-low reset
//   restart - realigns the divider so the next tick lands DIV clocks later
//   tick    - one-cycle pulse every DIV clocks
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clock,
  input  logic nreset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (!nreset)      cnt <= '0;
    else if (restart) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART (8N1 by default) with an oversampling receiver.
// Build option: define UART_PARITY_EN to insert an even-parity bit after
// the data bits in both directions.
// Ports:
//   clock, nreset          - system clock, synchronous active-low reset
//   tx_valid, tx_data      - frame request; data latched at accept
//   tx_busy, tx_sdata      - frame in flight, serial out (idle high)
//   rx_sdata               - asynchronous serial in
//   rx_data, rx_valid      - last good byte, one-cycle update strobe
//   rx_frame_err           - one-cycle strobe on bad stop (or parity)
module uart_txrx import uart_pkg::*; #(
  parameter int BYTESIZES           = DEF_BYTESIZES,
  parameter int RX_OVERSAMPLING     = DEF_RX_OS,
  parameter int TX_OVERSAMPLING     = DEF_TX_OS,
  parameter int BAUDRATE            = DEF_BAUDRATE,
  parameter int COUNTER_CLOCK_INPUT = DEF_CLOCK_HZ
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 tx_valid,
  input  logic [BYTESIZES-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_sdata,
  input  logic                 rx_sdata,
  output logic [BYTESIZES-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  localparam int TX_DIV = calc_div(COUNTER_CLOCK_INPUT, BAUDRATE, TX_OVERSAMPLING);
  localparam int RX_DIV = calc_div(COUNTER_CLOCK_INPUT, BAUDRATE, RX_OVERSAMPLING);
  localparam int BW     = $clog2(BYTESIZES);
  localparam int TOW    = (TX_OVERSAMPLING > 1) ? $clog2(TX_OVERSAMPLING) : 1;
  localparam int ROW    = $clog2(RX_OVERSAMPLING);
  localparam logic [BW-1:0] LAST_BIT = BW'(BYTESIZES - 1);
`ifdef UART_PARITY_EN
  localparam uart_state_e AFTER_DATA = PARITY;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  // ---------------- transmitter ----------------
  uart_state_e          tx_state, tx_state_n;
  logic                 tx_tick, tx_load, tx_bit_end;
  logic [TOW-1:0]       tx_os;
  logic [BW-1:0]        tx_bit;
  logic [BYTESIZES-1:0] tx_shift;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  uart_baud_gen #(.DIV(TX_DIV)) u_tx_baud (
    .clock, .nreset, .restart(tx_load), .tick(tx_tick)
  );

  assign tx_bit_end = tx_tick && (tx_os == TOW'(TX_OVERSAMPLING - 1));
  assign tx_busy    = (tx_state != IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_load    = 1'b0;
    tx_sdata   = 1'b1;
    case (tx_state)
      IDLE: if (tx_valid) begin
        tx_state_n = START;
        tx_load    = 1'b1;
      end
      START: begin
        tx_sdata = 1'b0;
        if (tx_bit_end) tx_state_n = DATA;
      end
      DATA: begin
        tx_sdata = tx_shift[0];
        if (tx_bit_end && tx_bit == LAST_BIT) tx_state_n = AFTER_DATA;
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        tx_sdata = tx_par;
        if (tx_bit_end) tx_state_n = STOP;
      end
`endif
      STOP: if (tx_bit_end) begin
        // Chain straight into the next start bit so streamed frames have no
        // idle clock between them.
        if (tx_valid) begin
          tx_state_n = START;
          tx_load    = 1'b1;
        end else begin
          tx_state_n = IDLE;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      tx_state <= IDLE;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      if (tx_load) begin
        tx_shift <= tx_data;
        tx_bit   <= '0;
        tx_os    <= '0;
`ifdef UART_PARITY_EN
        tx_par   <= ^tx_data;
`endif
      end else if (tx_bit_end) begin
        tx_os <= '0;
        if (tx_state == DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 1'b1;
        end
      end else if (tx_tick) begin
        tx_os <= tx_os + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  uart_state_e          rx_state, rx_state_n;
  logic                 rx_s1, rx_s2, rx_s3;
  logic                 rx_fall, rx_start, rx_tick, rx_mid_half, rx_mid, rx_good;
  logic [ROW-1:0]       rx_os;
  logic [BW-1:0]        rx_bit;
  logic [BYTESIZES-1:0] rx_shift;
`ifdef UART_PARITY_EN
  logic                 rx_par;
`endif

  // rx_s1/rx_s2 synchronize; rx_s3 is the previous synchronized sample.
  assign rx_fall  = rx_s3 & ~rx_s2;
  assign rx_start = (rx_state == IDLE) && rx_fall;

  uart_baud_gen #(.DIV(RX_DIV)) u_rx_baud (
    .clock, .nreset, .restart(rx_start), .tick(rx_tick)
  );

  assign rx_mid_half = rx_tick && (rx_os == ROW'(RX_OVERSAMPLING / 2 - 1));
  assign rx_mid      = rx_tick && (rx_os == ROW'(RX_OVERSAMPLING - 1));
`ifdef UART_PARITY_EN
  assign rx_good = rx_s2 && !((^rx_shift) ^ rx_par);
`else
  assign rx_good = rx_s2;
`endif

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      IDLE:  if (rx_fall) rx_state_n = START;
      // High at mid start bit means the edge was a glitch.
      START: if (rx_mid_half) rx_state_n = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_mid && rx_bit == LAST_BIT) rx_state_n = AFTER_DATA;
`ifdef UART_PARITY_EN
      PARITY: if (rx_mid) rx_state_n = STOP;
`endif
      STOP:  if (rx_mid) rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_s3        <= 1'b1;
      rx_state     <= IDLE;
      rx_os        <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par       <= 1'b0;
`endif
    end else begin
      rx_s1        <= rx_sdata;
      rx_s2        <= rx_s1;
      rx_s3        <= rx_s2;
      rx_state     <= rx_state_n;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rx_start) begin
        rx_os  <= '0;
        rx_bit <= '0;
      end else if (rx_tick) begin
        // Realign at mid start bit so later samples fall mid-bit.
        if ((rx_state == START && rx_mid_half) || rx_mid) rx_os <= '0;
        else                                              rx_os <= rx_os + 1'b1;
      end
      if (rx_mid) begin
        case (rx_state)
          DATA: begin
            rx_shift <= {rx_s2, rx_shift[BYTESIZES-1:1]};
            rx_bit   <= rx_bit + 1'b1;
          end
`ifdef UART_PARITY_EN
          PARITY: rx_par <= rx_s2;
`endif
          STOP: begin
            if (rx_good) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx at default parameters.
module tb_uart_txrx;

  localparam int BITCLK = 434;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLK = NBITS * BITCLK;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_sdata, rx_sdata, rx_valid, rx_frame_err;
  logic [7:0] rx_data;
  logic       loop = 1'b0;
  logic       drv = 1'b1;

  assign rx_sdata = loop ? tx_sdata : drv;

  uart_txrx dut (
    .clock(clock), .nreset(nreset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_busy(tx_busy), .tx_sdata(tx_sdata),
    .rx_sdata(rx_sdata), .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observed RX events, sampled mid-cycle.
  int         vq_cyc[$];
  logic [7:0] vq_data[$];
  int         eq_cyc[$];
  always @(negedge clock) begin
    if (rx_valid) begin
      vq_cyc.push_back(cyc);
      vq_data.push_back(rx_data);
    end
    if (rx_frame_err) eq_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    vq_cyc.delete();
    vq_data.delete();
    eq_cyc.delete();
  endtask

  // Reference frame: bit i of the serial frame for byte d (stop bit = 1).
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop);
    for (int i = 0; i < NBITS; i++) begin
      drv = (i == NBITS - 1) ? stop : exp_bit(d, i);
      repeat (BITCLK) @(negedge clock);
    end
    drv = 1'b1;
  endtask

  task automatic wait_tx_low(input string name, input int lim);
    int n;
    n = 0;
    while (tx_sdata !== 1'b0 && n < lim) begin
      @(negedge clock);
      n++;
    end
    if (tx_sdata !== 1'b0) chk(name, 32'(n), 32'(lim + 1));
  endtask

  // Called on the negedge where the start bit is first seen.
  task automatic check_tx_frame(input string tag, input logic [7:0] d);
    repeat (BITCLK / 2) @(negedge clock);
    for (int i = 0; i < NBITS; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), 32'(tx_sdata), 32'(exp_bit(d, i)));
      if (i < NBITS - 1) repeat (BITCLK) @(negedge clock);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       glitch;
    int         nv;
    int         ne;
    logic [7:0] xd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #950000;
    $display("FAIL watchdog: cycle %0d reached limit", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] prev;
    int n;

    tbl[0] = '{d: 8'hA5, stop: 1'b1, glitch: 1'b0, nv: 1, ne: 0, xd: 8'hA5};
    tbl[1] = '{d: 8'h3C, stop: 1'b1, glitch: 1'b1, nv: 1, ne: 0, xd: 8'h3C};
    tbl[2] = '{d: 8'h55, stop: 1'b0, glitch: 1'b0, nv: 0, ne: 1, xd: 8'h3C};
    prev = 8'h3C;
    for (int i = 3; i < 6; i++) begin
      tbl[i].d      = 8'($urandom);
      tbl[i].stop   = ($urandom_range(0, 3) != 0);
      tbl[i].glitch = 1'b0;
      tbl[i].nv     = tbl[i].stop ? 1 : 0;
      tbl[i].ne     = tbl[i].stop ? 0 : 1;
      tbl[i].xd     = tbl[i].stop ? tbl[i].d : prev;
      prev          = tbl[i].xd;
    end

    // Reset state
    repeat (5) @(negedge clock);
    chk("rst_tx_sdata", 32'(tx_sdata), 1);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_frame_err", 32'(rx_frame_err), 0);
    nreset = 1'b1;
    repeat (10) @(negedge clock);

    // RX-only vectors
    foreach (tbl[i]) begin
      if (tbl[i].glitch) begin
        clear_q();
        drv = 1'b0;
        repeat (100) @(negedge clock);
        drv = 1'b1;
        repeat (1000) @(negedge clock);
        chk("glitch_valid", 32'(vq_cyc.size()), 0);
        chk("glitch_err", 32'(eq_cyc.size()), 0);
      end
      clear_q();
      send_frame(tbl[i].d, tbl[i].stop);
      repeat (BITCLK) @(negedge clock);
      chk($sformatf("v%0d_nvalid", i), 32'(vq_cyc.size()), 32'(tbl[i].nv));
      chk($sformatf("v%0d_nerr", i), 32'(eq_cyc.size()), 32'(tbl[i].ne));
      chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(tbl[i].xd));
    end

    // Loopback, streaming 8'h80
    loop = 1'b1;
    repeat (10) @(negedge clock);
    clear_q();
    tx_data  = 8'h80;
    tx_valid = 1'b1;
    wait_tx_low("lb_start1", 100);
    chk("lb_busy", 32'(tx_busy), 1);
    check_tx_frame("lb_f1", 8'h80);
    wait_tx_low("lb_start2", BITCLK);
    n = 0;
    while (tx_sdata === 1'b0 && n < 10000) begin
      n++;
      @(negedge clock);
    end
    chk("lb_low_run", 32'(n), 32'(8 * BITCLK));
    n = 0;
    while (vq_cyc.size() < 3 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("lb_nvalid_ge3", 32'(vq_cyc.size() >= 3), 1);
    if (vq_cyc.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("lb_data%0d", i), 32'(vq_data[i]), 32'h80);
      chk("lb_period01", 32'(vq_cyc[1] - vq_cyc[0]), 32'(FRAME_CLK));
      chk("lb_period12", 32'(vq_cyc[2] - vq_cyc[1]), 32'(FRAME_CLK));
    end
    chk("lb_nerr", 32'(eq_cyc.size()), 0);

    // Reset during TX data bit 4
    wait_tx_low("mr_start", FRAME_CLK);
    repeat (BITCLK / 2 + 5 * BITCLK) @(negedge clock);
    nreset = 1'b0;
    @(negedge clock);
    chk("mr_tx_sdata", 32'(tx_sdata), 1);
    chk("mr_tx_busy", 32'(tx_busy), 0);
    chk("mr_rx_data", 32'(rx_data), 0);
    tx_data = 8'hA5;
    repeat (2) @(negedge clock);
    clear_q();
    nreset = 1'b1;
    wait_tx_low("mr_restart", 20);
    tx_valid = 1'b0;
    check_tx_frame("mr_f", 8'hA5);
    n = 0;
    while (vq_cyc.size() < 1 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("mr_nvalid", 32'(vq_cyc.size()), 1);
    chk("mr_rx_data_new", 32'(rx_data), 32'hA5);
    n = 0;
    while (tx_busy !== 1'b0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("mr_idle", 32'(tx_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex 8N1 UART for the peripheral bus.
- Contains an oversampling receiver and a transmitter that share one clock domain and one reset.
- Baud ticks are derived from the system clock by integer division.
- Typical integration: tx_sdata of one instance looped into rx_sdata, or both pins routed to board I/O.

Parameters:
- BYTESIZES, 8: data bits per frame, LSB first; legal range 5..9.
- RX_OVERSAMPLING, 16: receiver ticks per bit; must be even and at least 4.
- TX_OVERSAMPLING, 1: transmitter ticks per bit.
- BAUDRATE, 115200: line rate in bit/s.
- COUNTER_CLOCK_INPUT, 50_000_000: clock frequency in Hz.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- nreset  in  1  synchronous, active-low reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  BYTESIZES  byte to transmit; sampled when the frame is accepted.
- tx_busy  out  1  high while a frame is in flight.
- tx_sdata  out  1  serial output line; idle high.
- rx_sdata  in  1  serial input line; asynchronous.
- rx_data  out  BYTESIZES  last correctly received byte.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- rx_frame_err  out  1  one-cycle strobe when a frame has a bad stop bit.

Behaviour:
- Reset: when nreset=0 at a clock edge:
  - tx_sdata=1, tx_busy=0, rx_data=0, rx_valid=0, rx_frame_err=0.
  - All counters are cleared and both FSMs go to IDLE.
  - A reset mid-frame aborts the frame immediately; the line returns high on the next edge.
- Tick divisors are rounded to the nearest integer:
  - TX_DIV = round(COUNTER_CLOCK_INPUT / (BAUDRATE * TX_OVERSAMPLING)).
  - RX_DIV = round(COUNTER_CLOCK_INPUT / (BAUDRATE * RX_OVERSAMPLING)).
  - Defaults: TX_DIV=434 and RX_DIV=27, so one RX bit is 432 clocks.
- TX tick counter: free-running in IDLE, restarted at frame accept.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx_valid=1 and tx_busy=0 accepts the frame. tx_data is latched, tx_busy rises on the next edge, and tx_sdata=0 is driven for one bit (TX_DIV*TX_OVERSAMPLING clocks).
  - DATA: shifts out BYTESIZES bits, LSB first, one bit period each.
  - STOP: drives 1 for one bit period, then returns to IDLE.
  - If tx_valid is still high in IDLE, the next frame starts on the following edge. Back-to-back frames therefore have no idle gap; the period is (BYTESIZES+2) bit times, 4340 clocks at the defaults.
  - Changes on tx_data while tx_busy=1 are ignored.
- RX input conditioning: two-flop synchronizer, then edge detection on the synchronized signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE, all timing in RX ticks.
  - IDLE: a falling edge starts the tick counter.
  - START: samples the line at RX_OVERSAMPLING/2 ticks. If high it is a glitch: return to IDLE with no strobes. If low, continue.
  - DATA: samples every RX_OVERSAMPLING ticks (mid-bit) and shifts in LSB first for BYTESIZES bits.
  - STOP: samples mid-bit.
    - If 1: rx_data is loaded and rx_valid pulses high for exactly one clock.
    - If 0: rx_data is held and rx_frame_err pulses for one clock.
  - In both cases the FSM returns to IDLE and looks for the next falling edge.
  - After a framing error the RX ignores a line stuck low until it returns high.
- rx_data holds its value between strobes.
- Latency: rx_valid asserts about 9.5 bit times, plus 3 clocks, after the start-bit falling edge at the RX pin.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: an even-parity bit is inserted after the data bits in both directions, giving 11-bit frames at the defaults.
  - TX sends the XOR of the data bits.
  - RX checks parity. On mismatch it pulses rx_frame_err, suppresses rx_valid and leaves rx_data unchanged.
- Undefined: 8N1 framing exactly as described above.

Decomposition:
- Package uart_pkg holds:
  - typedef uart_state_e {IDLE, START, DATA, PARITY, STOP};
  - a function to compute the rounded divisors;
  - the default constants.
- One sub-module, uart_baud_gen, is instantiated twice (TX and RX).
  - Parameter: DIV.
  - Inputs: clock, nreset, restart.
  - Output: tick, a one-cycle pulse every DIV clocks.
- The TX and RX FSMs live in uart_txrx.

Test Plan:
- Reset: hold nreset=0 for 5 clocks. Require tx_sdata=1, tx_busy=0, rx_data=0, rx_valid=0, rx_frame_err=0.
- Loopback (tx_sdata tied to rx_sdata), tx_valid held 1, tx_data=8'h80:
  - the first rx_valid carries rx_data=8'h80;
  - later rx_valid pulses repeat every 4340 clocks;
  - tx_sdata shows a 0 start bit, seven 0s, one 1, then a 1 stop bit, 434 clocks per bit.
- RX alone: drive the 8'hA5 frame LSB first at 434 clocks/bit. Require rx_data=8'hA5 and exactly one rx_valid cycle.
- Glitch: drive rx_sdata low for 100 clocks, then high. Require no rx_valid and no rx_frame_err; a following valid frame of 8'h3C is received correctly.
- Framing error: send 8'h55 with the stop bit forced to 0. Require an rx_frame_err pulse and rx_data still at its previous value.
- Reset mid-frame: assert nreset=0 during TX bit 4. Require tx_sdata=1 on the next edge; after release with tx_valid=1, a clean new frame starts.
